fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares the single write port of the async FIFO (W_INC / WR_DATA / FULL) between NUM_REQ requesters in the write clock domain. Each requester pushes frames through a valid/ready/last handshake. A granted requester owns the port until its LAST word is accepted, so frames are never interleaved in the FIFO. The block sits directly in front of the FIFO write port and is clocked by the FIFO write clock.

Parameters:
DATA_WIDTH, 8, word width; equals the FIFO DATA_WIDTH.
NUM_REQ, 4, number of requesters (2..8).
IDX_WIDTH, 2, width of the requester index; must satisfy 2^IDX_WIDTH >= NUM_REQ.
CNT_WIDTH, 8, width of the frame word counter.

Ports:
CLK  in  1  FIFO write clock (same net as W_CLK).
RST  in  1  synchronous, active-high reset.
REQ_VALID  in  NUM_REQ  per-requester word valid.
REQ_LAST  in  NUM_REQ  marks the final word of a frame; qualified by REQ_VALID.
REQ_DATA  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ_READY  out  NUM_REQ  per-requester accept.
W_INC  out  1  FIFO write increment.
WR_DATA  out  DATA_WIDTH  FIFO write data.
FULL  in  1  FIFO full flag (write domain).
GRANT_ID  out  IDX_WIDTH  index of the current owner; valid while BUSY=1.
BUSY  out  1  a frame is in progress.
FRAME_CNT  out  CNT_WIDTH  words accepted in the current frame.

Behaviour:
- Reset is synchronous and active-high on CLK. When RST=1 at a rising edge:
  - state goes to IDLE; rr_ptr, owner and frame counter go to 0.
  - Outputs then read: BUSY=0, GRANT_ID=0, FRAME_CNT=0, REQ_READY=0, W_INC=0. WR_DATA is don't-care; it is driven from requester 0.
- A reset during a frame abandons the frame. Words already written stay in the FIFO. The FIFO is not flushed.
- States:
  - IDLE: REQ_READY=0 and W_INC=0.
    - If any REQ_VALID is set, pick the first set index starting at rr_ptr and wrapping modulo NUM_REQ.
    - Register that index as owner and go to LOCKED on the next edge.
    - Arbitration costs one cycle and no transfer happens in IDLE.
  - LOCKED:
    - Combinational outputs: REQ_READY[owner] = ~FULL; all other READY bits are 0; W_INC = REQ_VALID[owner] & ~FULL; WR_DATA = REQ_DATA[owner].
    - A transfer happens on an edge where REQ_VALID[owner] & REQ_READY[owner] is true; FRAME_CNT increments on each transfer.
    - A transfer with REQ_LAST[owner]=1 returns the block to IDLE, sets rr_ptr = (owner+1) mod NUM_REQ, and clears FRAME_CNT.
- W_INC is never asserted while FULL=1. The FIFO's own guard is redundant but harmless.
- FULL rising mid-frame: READY drops in the same cycle and ownership is kept. The word is not lost because the requester holds VALID and DATA.
- Owner deasserts VALID mid-frame: ownership is kept with no timeout. Other requesters wait.
- FRAME_CNT saturates at all-ones. Frame length is not limited.
- A single-word frame (VALID and LAST together) takes 2 cycles: one arbitration cycle plus one transfer cycle.
- Sustained throughput is one word per cycle within a frame. Frame-to-frame turnaround costs one idle cycle.
- Fairness: each waiting requester is granted within NUM_REQ-1 frames.
- REQ_LAST asserted without REQ_VALID is ignored.

Decomposition:
- Shared package holds the state encoding (IDLE=1'b0, LOCKED=1'b1) and the default values of DATA_WIDTH, NUM_REQ and IDX_WIDTH.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: found flag, selected index.
  - It is reusable for other shared resources.
- Datapath muxing and the FSM live in the top module.

Test Plan:
1. Reset, then REQ_VALID=0001 with a 3-word frame AA,BB,CC (LAST on CC), FULL=0 -> BUSY=1 and GRANT_ID=0 one cycle later; W_INC high for 3 cycles with WR_DATA AA,BB,CC; FRAME_CNT 1,2 then 0; BUSY=0 and rr_ptr=1 afterwards.
2. All four requesters hold single-word frames 10,20,30,40 continuously -> FIFO receives 10,20,30,40,10,... (grant order 0,1,2,3,0); one idle cycle between frames.
3. Owner 2 mid-frame while FULL asserts for 3 cycles -> REQ_READY[2]=0 and W_INC=0 for those 3 cycles; GRANT_ID stays 2; the held word is written on the first cycle after FULL=0; no duplicated or lost words.
4. Owner 1 drops VALID for 5 cycles mid-frame while requester 3 is valid -> no grant to 3 and W_INC=0 for those cycles; frame 1 completes, then requester 3 is granted.
5. RST pulse while owner 0 is on word 2 of a 4-word frame -> next cycle BUSY=0, REQ_READY=0, W_INC=0, FRAME_CNT=0; the next arbitration starts from index 0.
6. FULL=1 held through IDLE and LOCKED with requesters valid -> W_INC never asserts; check with an assertion across a random run.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding,
// default geometry and a small modulo-increment helper.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_IDX_WIDTH  = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  // Next index in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after rr_ptr, wrapping modulo NUM_REQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        off;
  int unsigned        sum;

  always_comb begin
    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner.
    rot   = NUM_REQ'({req, req} >> rr_ptr);
    found = |req;
    off   = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (rot[k-1]) off = k - 1;
    end
    sum = 32'(rr_ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    idx = IDX_WIDTH'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin frame arbiter in front of the async FIFO write port; a granted
// requester keeps the port until its LAST word is accepted.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  input  logic                          FULL,
  output logic [IDX_WIDTH-1:0]          GRANT_ID,
  output logic                          BUSY,
  output logic [CNT_WIDTH-1:0]          FRAME_CNT
);

  arb_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0] owner_q, owner_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_rr_pick (
    .req   (REQ_VALID),
    .rr_ptr(rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    REQ_READY = '0;
    W_INC     = 1'b0;
    WR_DATA   = words[owner_q];

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          REQ_READY[i] = (owner_q == IDX_WIDTH'(i)) && !FULL;
        end
        W_INC = REQ_VALID[owner_q] && !FULL;
        if (W_INC) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (REQ_LAST[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = IDX_WIDTH'(rr_next(32'(owner_q), NUM_REQ));
            cnt_d    = '0;
          end
        end
      end
    endcase
  end

  assign BUSY      = (state_q == LOCKED);
  assign GRANT_ID  = owner_q;
  assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed frame scenarios plus a randomized run
// checked against a frame-level round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          w_inc;
  logic [DW-1:0] wr_data;
  logic          full = 1'b0;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (N),
    .IDX_WIDTH (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ_VALID(req_valid),
    .REQ_LAST (req_last),
    .REQ_DATA (req_data),
    .REQ_READY(req_ready),
    .W_INC    (w_inc),
    .WR_DATA  (wr_data),
    .FULL     (full),
    .GRANT_ID (grant_id),
    .BUSY     (busy),
    .FRAME_CNT(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_last = '1; full = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (w_inc !== 1'b0) begin errors++; $display("FAIL reset_winc: got %0b want 0", w_inc); end
    rst = 1'b0; req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] fr [3];
    fr = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    req_valid = 4'b0001; set_word(0, fr[0]); req_last = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || w_inc !== 1'b0) begin errors++; $display("FAIL frame_arb_cycle: busy=%0b w_inc=%0b want 0 0", busy, w_inc); end
    tick();
    for (int k = 0; k < 3; k++) begin
      set_word(0, fr[k]); req_last[0] = (k == 2);
      @(negedge clk);
      checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL frame_grant[%0d]: busy=%0b grant=%0d want 1 0", k, busy, grant_id); end
      checks++; if (w_inc !== 1'b1 || wr_data !== fr[k]) begin errors++; $display("FAIL frame_word[%0d]: w_inc=%0b data=%h want 1 %h", k, w_inc, wr_data, fr[k]); end
      checks++; if (frame_cnt !== CW'(k)) begin errors++; $display("FAIL frame_cnt[%0d]: got %0d want %0d", k, frame_cnt, k); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL frame_ready[%0d]: got %b want 0001", k, req_ready); end
      tick();
    end
    req_valid = '0; req_last = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || frame_cnt !== 8'd0 || w_inc !== 1'b0) begin errors++; $display("FAIL frame_end: busy=%0b cnt=%0d w_inc=%0b want 0 0 0", busy, frame_cnt, w_inc); end
    // Requesters 0 and 1 both valid: pointer must now favour 1.
    req_valid = 4'b0011; req_last = 4'b0011; set_word(1, 8'h11);
    tick();
    @(negedge clk);
    checks++; if (grant_id !== 2'd1 || wr_data !== 8'h11) begin errors++; $display("FAIL frame_next_ptr: grant=%0d data=%h want 1 11", grant_id, wr_data); end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, DW'((i + 1) * 16));
    req_valid = '1; req_last = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        checks++; if (w_inc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: w_inc=%0b busy=%0b want 0 0", c, w_inc, busy); end
      end else begin
        checks++;
        if (w_inc !== 1'b1 || grant_id !== IW'(order[c/2]) || wr_data !== DW'((order[c/2] + 1) * 16)) begin
          errors++; $display("FAIL rr_xfer[%0d]: w_inc=%0b grant=%0d data=%h want 1 %0d %h", c, w_inc, grant_id, wr_data, order[c/2], (order[c/2] + 1) * 16);
        end
      end
      tick();
    end
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0100; set_word(2, 8'h51); req_last = '0;
    tick();
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h51 || grant_id !== 2'd2) begin errors++; $display("FAIL stall_w0: w_inc=%0b data=%h grant=%0d want 1 51 2", w_inc, wr_data, grant_id); end
    tick();
    set_word(2, 8'h52);
    tick();
    set_word(2, 8'h53); full = 1'b1; req_valid[0] = 1'b1; req_last[0] = 1'b1; set_word(0, 8'h01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000 || w_inc !== 1'b0) begin errors++; $display("FAIL stall_full[%0d]: ready=%b w_inc=%0b want 0000 0", c, req_ready, w_inc); end
      checks++; if (grant_id !== 2'd2 || busy !== 1'b1 || frame_cnt !== 8'd2) begin errors++; $display("FAIL stall_hold[%0d]: grant=%0d busy=%0b cnt=%0d want 2 1 2", c, grant_id, busy, frame_cnt); end
      tick();
    end
    full = 1'b0;
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h53 || req_ready !== 4'b0100) begin errors++; $display("FAIL stall_resume: w_inc=%0b data=%h ready=%b want 1 53 0100", w_inc, wr_data, req_ready); end
    tick();
    set_word(2, 8'h54); req_last[2] = 1'b1;
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h54 || frame_cnt !== 8'd3) begin errors++; $display("FAIL stall_last: w_inc=%0b data=%h cnt=%0d want 1 54 3", w_inc, wr_data, frame_cnt); end
    tick();
    req_valid[2] = 1'b0; req_last[2] = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (grant_id !== 2'd0 || w_inc !== 1'b1 || wr_data !== 8'h01) begin errors++; $display("FAIL stall_wrap: grant=%0d w_inc=%0b data=%h want 0 1 01", grant_id, w_inc, wr_data); end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_valid_gap();
    do_reset();
    req_valid = 4'b0010; set_word(1, 8'h61); req_last = '0;
    tick();
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h61 || grant_id !== 2'd1) begin errors++; $display("FAIL gap_w0: w_inc=%0b data=%h grant=%0d want 1 61 1", w_inc, wr_data, grant_id); end
    tick();
    // LAST on the idle owner without VALID must not close the frame.
    req_valid = 4'b1000; set_word(3, 8'h71); req_last = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (w_inc !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL gap_hold[%0d]: w_inc=%0b grant=%0d busy=%0b want 0 1 1", c, w_inc, grant_id, busy); end
      checks++; if (req_ready !== 4'b0010 || frame_cnt !== 8'd1) begin errors++; $display("FAIL gap_ready[%0d]: ready=%b cnt=%0d want 0010 1", c, req_ready, frame_cnt); end
      tick();
    end
    req_valid = 4'b1010; set_word(1, 8'h62); req_last = 4'b1000;
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h62 || frame_cnt !== 8'd1) begin errors++; $display("FAIL gap_w1: w_inc=%0b data=%h cnt=%0d want 1 62 1", w_inc, wr_data, frame_cnt); end
    tick();
    set_word(1, 8'h63); req_last = 4'b1010;
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h63 || frame_cnt !== 8'd2) begin errors++; $display("FAIL gap_w2: w_inc=%0b data=%h cnt=%0d want 1 63 2", w_inc, wr_data, frame_cnt); end
    tick();
    req_valid = 4'b1000; req_last = 4'b1000;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || w_inc !== 1'b0) begin errors++; $display("FAIL gap_turn: busy=%0b w_inc=%0b want 0 0", busy, w_inc); end
    tick();
    @(negedge clk);
    checks++; if (grant_id !== 2'd3 || w_inc !== 1'b1 || wr_data !== 8'h71) begin errors++; $display("FAIL gap_next: grant=%0d w_inc=%0b data=%h want 3 1 71", grant_id, w_inc, wr_data); end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req_valid = 4'b0001; set_word(0, 8'h81); req_last = '0;
    tick();
    tick();
    set_word(0, 8'h82);
    @(negedge clk);
    checks++; if (w_inc !== 1'b1 || wr_data !== 8'h82 || frame_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_w1: w_inc=%0b data=%h cnt=%0d want 1 82 1", w_inc, wr_data, frame_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0011; set_word(1, 8'h91); req_last = 4'b0011;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0000 || w_inc !== 1'b0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_clear: busy=%0b ready=%b w_inc=%0b cnt=%0d want 0 0000 0 0", busy, req_ready, w_inc, frame_cnt); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_ptr: busy=%0b grant=%0d want 1 0", busy, grant_id); end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    req_valid = 4'b0001; req_last = '0;
    tick();
    for (int k = 0; k < 260; k++) begin
      set_word(0, DW'(k));
      exp = (k > 255) ? 255 : k;
      @(negedge clk);
      checks++; if (frame_cnt !== CW'(exp) || w_inc !== 1'b1) begin errors++; $display("FAIL sat_cnt[%0d]: cnt=%0d w_inc=%0b want %0d 1", k, frame_cnt, w_inc, exp); end
      tick();
    end
    req_last[0] = 1'b1;
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL sat_clear: busy=%0b cnt=%0d want 0 0", busy, frame_cnt); end
    tick();
  endtask

  // Reference model: frame-level round robin over the words each requester
  // offers; requesters hold a word until the arbiter takes it.
  task automatic test_random();
    bit            m_busy;
    int            m_owner, m_ptr, m_cnt;
    int unsigned   gseq [N];
    int            grem [N];
    bit            pres [N];
    logic [N-1:0]  exp_ready;
    bit            exp_winc;
    logic [DW-1:0] exp_data;
    do_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      gseq[i] = 0; grem[i] = $urandom_range(1, 5); pres[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      full = (cyc < 8) ? 1'b1 : ((cyc % 200) < 20) ? 1'b1 : ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && $urandom_range(0, 2) != 0) pres[i] = 1;
        req_valid[i] = pres[i];
        set_word(i, {2'(i), 6'(gseq[i])});
        req_last[i] = pres[i] ? (grem[i] == 1) : 1'($urandom_range(0, 1));
      end
      exp_ready = '0;
      if (m_busy && !full) exp_ready[m_owner] = 1'b1;
      exp_winc = m_busy && pres[m_owner] && !full;
      exp_data = {2'(m_owner), 6'(gseq[m_owner])};
      @(negedge clk);
      checks++;
      assert (!(w_inc && full)) else begin errors++; $display("FAIL rnd_winc_full[%0d]: w_inc=%0b full=%0b", cyc, w_inc, full); end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_ready); end
      checks++; if (w_inc !== exp_winc) begin errors++; $display("FAIL rnd_winc[%0d]: got %0b want %0b", cyc, w_inc, exp_winc); end
      if (exp_winc) begin
        checks++; if (wr_data !== exp_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, wr_data, exp_data); end
      end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", cyc, busy, m_busy); end
      if (m_busy) begin
        checks++; if (grant_id !== IW'(m_owner)) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", cyc, grant_id, m_owner); end
      end
      checks++; if (frame_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", cyc, frame_cnt, m_cnt); end
      @(posedge clk);
      if (!m_busy) begin
        if (req_valid != '0) begin
          for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              break;
            end
          end
          m_busy = 1;
        end
      end else if (exp_winc) begin
        if (m_cnt < 255) m_cnt++;
        if (grem[m_owner] == 1) begin
          m_busy = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
        end
        gseq[m_owner]++;
        grem[m_owner]--;
        if (grem[m_owner] == 0) grem[m_owner] = $urandom_range(1, 5);
        pres[m_owner] = 0;
      end
      #1;
    end
    full = 1'b0; req_valid = '0; req_last = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_full_stall();
    test_valid_gap();
    test_reset_mid_frame();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
